// File: rtl/wb_writeback_arbiter_if.sv
// Writeback arbiter bus bundle: pipeline result, long-latency stream, RF port.
// The arbiter attaches through the slave modport; the producer side uses master.
interface wb_writeback_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            pipe_valid;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_data;

    logic            ll_valid;
    logic            ll_ready;
    logic [4:0]      ll_rd;
    logic [XLEN-1:0] ll_data;

    logic            rf_RegWrite;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_in;

    logic [CW-1:0]   ll_count;
    logic            stall_req;

    modport master (
        output pipe_valid, pipe_rd, pipe_data,
        output ll_valid, ll_rd, ll_data,
        input  ll_ready,
        input  rf_RegWrite, rf_rd, rf_in,
        input  ll_count, stall_req
    );

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data,
        input  ll_valid, ll_rd, ll_data,
        output ll_ready,
        output rf_RegWrite, rf_rd, rf_in,
        output ll_count, stall_req
    );
endinterface

// File: rtl/wb_writeback_arbiter.sv
// Writeback arbiter: pipeline results win the RF port, long-latency results
// queue in a FIFO; optional busy_mask port enabled by macro WB_BUSY_MASK_EN.
module wb_writeback_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    wb_writeback_arbiter_if.slave   bus
`ifdef WB_BUSY_MASK_EN
    ,
    output logic [31:0]             busy_mask
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BLOCKED,
        STALL
    } state_t;

    logic [4:0]      q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;

    state_t          state;
    logic [SW-1:0]   starve;
    logic [SW-1:0]   starve_inc;

    logic            full;
    logic            empty;
    logic            push;
    logic            pipe_win;
    logic            pop;
    logic            blocked;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign bus.ll_ready = !rst && !full;
    assign bus.ll_count = count;

    // x0 destinations complete the handshake but are never stored.
    assign push     = bus.ll_valid && bus.ll_ready && (bus.ll_rd != 5'd0);
    // A pipeline write to x0 is no write, so it leaves the port to the FIFO.
    assign pipe_win = bus.pipe_valid && (bus.pipe_rd != 5'd0);
    assign pop      = !rst && !pipe_win && !empty;
    assign blocked  = pipe_win && !empty;

    assign starve_inc = starve + SW'(1);

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q_rd[wptr]   <= bus.ll_rd;
                q_data[wptr] <= bus.ll_data;
                wptr         <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered register-file write port; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rf_RegWrite <= 1'b0;
            bus.rf_rd       <= '0;
            bus.rf_in       <= '0;
        end else if (pipe_win) begin
            bus.rf_RegWrite <= 1'b1;
            bus.rf_rd       <= bus.pipe_rd;
            bus.rf_in       <= bus.pipe_data;
        end else if (pop) begin
            bus.rf_RegWrite <= 1'b1;
            bus.rf_rd       <= q_rd[rptr];
            bus.rf_in       <= q_data[rptr];
        end else begin
            bus.rf_RegWrite <= 1'b0;
        end
    end

    // Starvation tracker: counts cycles the FIFO head loses to the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            starve        <= '0;
            bus.stall_req <= 1'b0;
        end else if (!blocked) begin
            // Either the FIFO is empty or its head popped this cycle.
            state         <= IDLE;
            starve        <= '0;
            bus.stall_req <= 1'b0;
        end else begin
            unique case (state)
                IDLE, BLOCKED: begin
                    starve <= starve_inc;
                    if (starve_inc >= SW'(STARVE_LIMIT)) begin
                        state         <= STALL;
                        bus.stall_req <= 1'b1;
                    end else begin
                        state <= BLOCKED;
                    end
                end
                STALL: begin
                    state         <= STALL;
                    bus.stall_req <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    starve        <= '0;
                    bus.stall_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_BUSY_MASK_EN
    logic [AW-1:0] mask_idx;

    // One bit per destination held by a live FIFO entry; x0 never marked.
    always_comb begin
        busy_mask = '0;
        mask_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mask_idx = rptr + AW'(i);
            if (CW'(i) < count) begin
                busy_mask[q_rd[mask_idx]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end
`endif

endmodule

// File: tb/tb_wb_writeback_arbiter.sv
// Directed self-checking bench for wb_writeback_arbiter.
// Expected values are hand-derived from the arbiter's described behaviour.
module tb_wb_writeback_arbiter;
    localparam int XLEN = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    wb_writeback_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

`ifdef WB_BUSY_MASK_EN
    logic [31:0] busy_mask;
`endif

    wb_writeback_arbiter #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .STARVE_LIMIT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef WB_BUSY_MASK_EN
        ,
        .busy_mask(busy_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic v, input logic [4:0] rd,
                        input logic [31:0] d);
        bus.pipe_valid = v;
        bus.pipe_rd    = rd;
        bus.pipe_data  = d;
    endtask

    task automatic ll(input logic v, input logic [4:0] rd,
                      input logic [31:0] d);
        bus.ll_valid = v;
        bus.ll_rd    = rd;
        bus.ll_data  = d;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        pipe(1'b0, 5'd0, 32'h0);
        ll(1'b1, 5'd3, 32'h33);

        // Reset held two cycles with ll_valid high.
        tick();
        tick();
        check("rst_ready", 64'(bus.ll_ready), 64'd0);
        check("rst_we", 64'(bus.rf_RegWrite), 64'd0);
        check("rst_count", 64'(bus.ll_count), 64'd0);
        check("rst_stall", 64'(bus.stall_req), 64'd0);
        check("rst_rd", 64'(bus.rf_rd), 64'd0);
        rst = 1'b0;
        ll(1'b0, 5'd0, 32'h0);
        #1;
        check("ready_after_rst", 64'(bus.ll_ready), 64'd1);

        // Pipeline only.
        pipe(1'b1, 5'd5, 32'h5);
        tick();
        check("pipe_we", 64'(bus.rf_RegWrite), 64'd1);
        check("pipe_rd", 64'(bus.rf_rd), 64'd5);
        check("pipe_in", 64'(bus.rf_in), 64'd5);
        pipe(1'b0, 5'd0, 32'h0);
        tick();
        check("idle_we", 64'(bus.rf_RegWrite), 64'd0);
        check("idle_hold_rd", 64'(bus.rf_rd), 64'd5);
        check("idle_hold_in", 64'(bus.rf_in), 64'd5);

        // Fill FIFO under constant pipeline pressure.
        for (int k = 1; k <= 4; k++) begin
            pipe(1'b1, 5'd9, 32'h900 + 32'(k));
            ll(1'b1, 5'(k), 32'h11 * 32'(k));
            #1;
            check("fill_ready", 64'(bus.ll_ready), 64'd1);
            tick();
            check("fill_pipe_rd", 64'(bus.rf_rd), 64'd9);
        end
        check("full_count", 64'(bus.ll_count), 64'd4);
        check("full_ready", 64'(bus.ll_ready), 64'd0);
        // Offer more while full; blocked cycles 4..7 so far.
        ll(1'b1, 5'd15, 32'hFF);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stall_early", 64'(bus.stall_req), 64'd0);
        end
        tick();
        check("stall_set", 64'(bus.stall_req), 64'd1);
        check("full_hold", 64'(bus.ll_count), 64'd4);
        check("full_in", 64'(bus.rf_in), 64'h909 - 64'h5);
        ll(1'b0, 5'd0, 32'h0);
        pipe(1'b0, 5'd0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("drain_we", 64'(bus.rf_RegWrite), 64'd1);
            check("drain_rd", 64'(bus.rf_rd), 64'(k));
            check("drain_in", 64'(bus.rf_in), 64'(32'h11 * 32'(k)));
            check("drain_stall", 64'(bus.stall_req), 64'd0);
            check("drain_count", 64'(bus.ll_count), 64'(4 - k));
        end
        tick();
        check("drained_we", 64'(bus.rf_RegWrite), 64'd0);

        // x0 filtering on pipeline side lets FIFO pop.
        pipe(1'b1, 5'd0, 32'hDEAD);
        ll(1'b1, 5'd7, 32'h77);
        tick();
        check("x0_push_we", 64'(bus.rf_RegWrite), 64'd0);
        check("x0_push_count", 64'(bus.ll_count), 64'd1);
        ll(1'b0, 5'd0, 32'h0);
        tick();
        check("x0_pop_rd", 64'(bus.rf_rd), 64'd7);
        check("x0_pop_in", 64'(bus.rf_in), 64'h77);
        check("x0_pop_count", 64'(bus.ll_count), 64'd0);
        // x0 on the long-latency side is accepted and dropped.
        pipe(1'b0, 5'd0, 32'h0);
        ll(1'b1, 5'd0, 32'hBAD);
        #1;
        check("llx0_ready", 64'(bus.ll_ready), 64'd1);
        tick();
        check("llx0_count", 64'(bus.ll_count), 64'd0);
        check("llx0_we", 64'(bus.rf_RegWrite), 64'd0);

        // Same-cycle push and pop with two entries buffered.
        pipe(1'b1, 5'd9, 32'h999);
        ll(1'b1, 5'd10, 32'hA0);
        tick();
        ll(1'b1, 5'd11, 32'hB0);
        tick();
        check("pp_count2", 64'(bus.ll_count), 64'd2);
        pipe(1'b0, 5'd0, 32'h0);
        ll(1'b1, 5'd12, 32'hC0);
        tick();
        check("pp_count", 64'(bus.ll_count), 64'd2);
        check("pp_rd0", 64'(bus.rf_rd), 64'd10);
        ll(1'b0, 5'd0, 32'h0);
        tick();
        check("pp_rd1", 64'(bus.rf_in), 64'hB0);
        tick();
        check("pp_rd2", 64'(bus.rf_in), 64'hC0);
        check("pp_empty", 64'(bus.ll_count), 64'd0);

`ifdef WB_BUSY_MASK_EN
        pipe(1'b1, 5'd9, 32'h999);
        ll(1'b1, 5'd3, 32'h3);
        tick();
        check("mask_set", 64'(busy_mask), 64'h8);
        ll(1'b0, 5'd0, 32'h0);
        pipe(1'b0, 5'd0, 32'h0);
        tick();
        check("mask_clr", 64'(busy_mask), 64'h0);
`endif

        // Reset mid-queue discards entries, no stale write afterwards.
        pipe(1'b1, 5'd9, 32'h999);
        ll(1'b1, 5'd20, 32'h20);
        tick();
        ll(1'b1, 5'd21, 32'h21);
        tick();
        check("mq_count", 64'(bus.ll_count), 64'd2);
        ll(1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        tick();
        check("mq_rst_we", 64'(bus.rf_RegWrite), 64'd0);
        check("mq_rst_count", 64'(bus.ll_count), 64'd0);
`ifdef WB_BUSY_MASK_EN
        check("mq_rst_mask", 64'(busy_mask), 64'h0);
`endif
        rst = 1'b0;
        pipe(1'b0, 5'd0, 32'h0);
        tick();
        check("mq_no_stale", 64'(bus.rf_RegWrite), 64'd0);
        tick();
        check("mq_no_stale2", 64'(bus.rf_RegWrite), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_writeback_arbiter.md
# wb_writeback_arbiter

Writeback-side arbiter that drives the single write port of `register_file` (`rd`, `in`, `RegWrite`). It merges two result sources: the in-order pipeline writeback, which is always accepted and has priority, and a long-latency unit result stream (divider, load miss), which uses valid/ready and is buffered in a FIFO. Writes to x0 are filtered. Sustained pipeline pressure raises a stall request so that buffered results are eventually retired.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `DEPTH`, 4, long-latency FIFO entries; power of two, ≥ 2.
- `STARVE_LIMIT`, 8, consecutive blocked cycles before `stall_req` asserts; ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pipe_valid`  in  1  pipeline result present this cycle; no ready, always consumed.
- `pipe_rd`  in  5  pipeline destination register.
- `pipe_data`  in  XLEN  pipeline result.
- `ll_valid`  in  1  long-latency result offered.
- `ll_ready`  out  1  FIFO can accept; equals `!full`, forced 0 while `rst` is high.
- `ll_rd`  in  5  long-latency destination.
- `ll_data`  in  XLEN  long-latency result.
- `rf_RegWrite`  out  1  registered write enable to `register_file`.
- `rf_rd`  out  5  registered write address.
- `rf_in`  out  XLEN  registered write data.
- `ll_count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `stall_req`  out  1  registered request for the pipeline to insert bubbles.
- `busy_mask`  out  32  present only with `WB_BUSY_MASK_EN` (see Configuration).

## Operation
- **Reset:** `rf_RegWrite`=0, `rf_rd`=0, `rf_in`=0, FIFO empty, `ll_count`=0, `stall_req`=0, starve counter 0.
- **Enqueue:** occurs when `ll_valid && ll_ready`.
  - If `ll_rd`≠0, the entry is written at the tail.
  - If `ll_rd`==0, the handshake completes but nothing is enqueued.
- **Write-port selection** (each cycle, in priority order):
  1. If `pipe_valid && pipe_rd≠0`: register the pipeline result (`rf_RegWrite`=1).
  2. Else if FIFO is non-empty: pop the head and register it (`rf_RegWrite`=1).
  3. Else: `rf_RegWrite`=0. `rf_rd` and `rf_in` hold their previous values.
- **Ordering:**
  - FIFO entries retire in strict arrival order.
  - A pipeline write to x0 counts as no write, so the FIFO may pop in that cycle.
- **Same-cycle push and pop:**
  - Allowed when not full; `ll_count` is unchanged.
  - When full, `ll_ready`=0 even if a pop occurs in the same cycle. There is no combinational ready-through-pop path.
- **Starvation FSM:**
  - States: IDLE, BLOCKED, STALL.
  - IDLE → BLOCKED when FIFO is non-empty and the pipeline wins.
  - In BLOCKED, the counter increments each blocked cycle. A pop returns the FSM to IDLE and clears the counter.
  - BLOCKED → STALL when the counter reaches `STARVE_LIMIT`; `stall_req`=1 from the next cycle.
  - STALL → IDLE on the first pop. `stall_req` drops on the cycle after that pop.
  - An empty FIFO in any state forces IDLE.
- **Reset mid-operation:** all buffered entries are discarded and no write is issued during the cycles `rst` is high.

## Timing
- **Pipeline latency:** 1 cycle. Inputs sampled at edge N produce `rf_*` valid after edge N, so `register_file` writes at edge N+1.
- **Long-latency latency:** 2 cycles minimum. Enqueue at edge N; head popped and registered at edge N+1 if the pipeline is idle.
- **Throughput:** one register-file write per cycle.
- **Full condition:** `ll_ready` is combinational from registered occupancy only; `ll_count`==DEPTH ⇒ `ll_ready`=0.
- **Pointer wrap:** read and write pointers wrap modulo DEPTH. The extra count bit distinguishes full from empty.

## Configuration
- **`WB_BUSY_MASK_EN` defined:**
  - `busy_mask` port exists.
  - Bit r=1 when any valid FIFO entry targets register r; bit 0 is always 0.
  - Combinational from FIFO contents.
  - The decode stage uses it for RAW interlock.
- **`WB_BUSY_MASK_EN` undefined:** port and logic absent; all other behaviour identical.

## Test plan
- **Reset:** hold `rst` 2 cycles with `ll_valid`=1 → `ll_ready`=0, `rf_RegWrite`=0, `ll_count`=0.
- **Pipeline only:** `pipe_valid`=1, `pipe_rd`=5, `pipe_data`=0x5 → next cycle `rf_RegWrite`=1, `rf_rd`=5, `rf_in`=5; `register_file` `out1` reads 5 when `rs1`=5.
- **Full FIFO with pipeline pressure:** `ll_valid` pushes rd 1..4 (data 0x11..0x44) with `pipe_valid` high throughout → `ll_count`=4, `ll_ready`=0. After `STARVE_LIMIT`=8 blocked cycles `stall_req`=1. Drop `pipe_valid` → writes 0x11, 0x22, 0x33, 0x44 in order; `stall_req`=0 after the first pop.
- **x0 filtering:** `pipe_rd`=0 with FIFO holding rd=7 → FIFO pops the same cycle (`rf_rd`=7). Separately, `ll_rd`=0 accepted → `ll_count` unchanged.
- **Same-cycle push/pop:** 2 entries, pipeline idle, push → `ll_count` stays 2 and FIFO order is preserved.
- **Busy mask (with `WB_BUSY_MASK_EN`):** enqueue rd=3 → `busy_mask`=0x8. After retire, `busy_mask`=0. Assert `rst` mid-queue → `busy_mask`=0 and no stale write.
